// File: rtl/rpc2_ctrl_fifo_rd_pack_if.sv
// Bundles the command, FIFO read and packed-beat stream signals of the read-side drain engine.
// The master modport is the drain engine's view; slave is the surrounding environment.
interface rpc2_ctrl_fifo_rd_pack_if #(
    parameter int IN_WIDTH = 16,
    parameter int LEN_BITS = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_BITS-1:0]   cmd_len;
    logic                  fifo_rd_en;
    logic [IN_WIDTH-1:0]   fifo_rd_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [2*IN_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_len, fifo_rd_data, fifo_empty, m_ready,
        output cmd_ready, fifo_rd_en, m_valid, m_data, m_last, busy
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_rd_data, fifo_empty, m_ready,
        input  cmd_ready, fifo_rd_en, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/rpc2_ctrl_fifo_rd_pack.sv
// Drains the 16-bit controller FIFO, packs word pairs into 32-bit beats and frames each
// burst with a last flag; a 4-entry queue plus one in-flight credit absorbs read latency.
module rpc2_ctrl_fifo_rd_pack #(
    parameter int IN_WIDTH = 16,
    parameter int LEN_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    rpc2_ctrl_fifo_rd_pack_if.master bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LEN_BITS:0]   BEAT_ONE = {{LEN_BITS{1'b0}}, 1'b1};
    localparam logic [LEN_BITS+1:0] WORD_ONE = {{(LEN_BITS+1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [LEN_BITS:0]   beats_total_r;
    logic [LEN_BITS:0]   beat_cnt_r;
    logic [LEN_BITS+1:0] words_to_req_r;
    logic [IN_WIDTH-1:0] queue_r [4];
    logic [1:0]          head_r;
    logic [1:0]          tail_r;
    logic [2:0]          occ_r;
    logic                inflight_r;

    logic                rd_en_s;
    logic                m_valid_s;
    logic                m_last_s;
    logic                accept_s;
    logic [2:0]          credit_s;
    logic [2:0]          occ_next_s;
    logic [LEN_BITS:0]   cmd_beats_s;
    logic [LEN_BITS:0]   last_idx_s;

    // Pop issue, beat presentation and queue occupancy bookkeeping for this cycle.
    always_comb begin
        credit_s    = occ_r + {2'b00, inflight_r};
        cmd_beats_s = {1'b0, bus.cmd_len} + BEAT_ONE;
        last_idx_s  = beats_total_r - BEAT_ONE;
        // The in-flight word already owns a queue slot, so the credit limit prevents overflow.
        if ((state_r == RUN) && !bus.fifo_empty && (words_to_req_r != '0) && (credit_s < 3'd4)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        m_valid_s = (state_r == RUN) && (occ_r >= 3'd2);
        m_last_s  = m_valid_s && (beat_cnt_r == last_idx_s);
        accept_s  = m_valid_s && bus.m_ready;
        if (accept_s) begin
            occ_next_s = occ_r + {2'b00, inflight_r} - 3'd2;
        end else begin
            occ_next_s = occ_r + {2'b00, inflight_r};
        end
    end

    // Stream outputs come only from state and queue registers, never from m_ready.
    assign bus.cmd_ready  = (state_r == IDLE);
    assign bus.busy       = (state_r == RUN);
    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = m_valid_s;
    assign bus.m_last     = m_last_s;
    assign bus.m_data     = {queue_r[head_r + 2'd1], queue_r[head_r]};

    // Burst FSM together with the queue, pointers and request/beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            beats_total_r  <= '0;
            beat_cnt_r     <= '0;
            words_to_req_r <= '0;
            head_r         <= 2'd0;
            tail_r         <= 2'd0;
            occ_r          <= 3'd0;
            inflight_r     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                queue_r[i] <= '0;
            end
        end else begin
            inflight_r <= rd_en_s;
            occ_r      <= occ_next_s;
            if (inflight_r) begin
                queue_r[tail_r] <= bus.fifo_rd_data;
                tail_r          <= tail_r + 2'd1;
            end
            if (accept_s) begin
                head_r     <= head_r + 2'd2;
                beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            end
            if (rd_en_s) begin
                words_to_req_r <= words_to_req_r - WORD_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state_r        <= RUN;
                        beats_total_r  <= cmd_beats_s;
                        words_to_req_r <= {cmd_beats_s, 1'b0};
                        beat_cnt_r     <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (accept_s && m_last_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rpc2_ctrl_fifo_rd_pack.sv
// Bench for the FIFO read-side packer: a registered-empty FIFO model feeds the block and a
// word-stream scoreboard predicts every packed beat, its last flag and the total pop count.
module tb_rpc2_ctrl_fifo_rd_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rpc2_ctrl_fifo_rd_pack_if #(.IN_WIDTH(16), .LEN_BITS(8)) bus_if ();

    rpc2_ctrl_fifo_rd_pack #(.IN_WIDTH(16), .LEN_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fifo_q [$];
    logic [15:0] src_q  [$];
    logic [15:0] feed_q [$];

    int   pops, beat_idx, burst_len, last_cnt, beats_seen;
    int   feed_gap, feed_ctr, ready_mode;
    bit   done, hold_valid;
    logic [31:0] hold_data;
    logic        hold_last;

    // FIFO model: one-cycle read latency and an empty flag registered from its contents.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            bus_if.fifo_empty   <= 1'b1;
            bus_if.fifo_rd_data <= 16'h0000;
        end else begin
            if (bus_if.fifo_rd_en && !bus_if.fifo_empty && (fifo_q.size() > 0)) begin
                bus_if.fifo_rd_data <= fifo_q.pop_front();
            end
            bus_if.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input logic [15:0] w);
        fifo_q.push_back(w);
        src_q.push_back(w);
    endtask

    // One clock period: drive inputs, check the current outputs, then wait for the next negedge.
    task automatic cycle();
        logic [31:0] exp_data;
        if (feed_q.size() > 0) begin
            if (feed_ctr == 0) begin
                put_word(feed_q.pop_front());
                feed_ctr = feed_gap;
            end else begin
                feed_ctr--;
            end
        end
        case (ready_mode)
            0: bus_if.m_ready = 1'b1;
            1: bus_if.m_ready = 1'b0;
            default: bus_if.m_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus_if.fifo_rd_en) begin
            chk("rd_when_empty", bus_if.fifo_empty, 1'b0);
            if (!bus_if.fifo_empty) pops++;
        end
        if (hold_valid) begin
            chk("hold_valid", bus_if.m_valid, 1'b1);
            chk("hold_data", bus_if.m_data, hold_data);
            chk("hold_last", bus_if.m_last, hold_last);
        end
        if (bus_if.m_valid && bus_if.m_ready) begin
            chk("beat_in_burst", (!done && beat_idx <= burst_len), 1'b1);
            chk("pair_supplied", (src_q.size() >= 2), 1'b1);
            if (src_q.size() >= 2) begin
                exp_data = {src_q[1], src_q[0]};
                void'(src_q.pop_front());
                void'(src_q.pop_front());
                chk("beat_data", bus_if.m_data, exp_data);
            end
            chk("beat_last", bus_if.m_last, (beat_idx == burst_len));
            if (bus_if.m_last) last_cnt++;
            beat_idx++;
            beats_seen++;
            if (beat_idx == burst_len + 1) done = 1'b1;
        end
        hold_valid = bus_if.m_valid && !bus_if.m_ready;
        hold_data  = bus_if.m_data;
        hold_last  = bus_if.m_last;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_len   = 8'd0;
        bus_if.m_ready   = 1'b1;
        feed_q.delete();
        src_q.delete();
        hold_valid = 1'b0;
        done       = 1'b1;
        ready_mode = 0;
        feed_gap   = 0;
        feed_ctr   = 0;
        #1;
        chk("rst_cmd_ready", bus_if.cmd_ready, 1'b1);
        chk("rst_rd_en", bus_if.fifo_rd_en, 1'b0);
        chk("rst_m_valid", bus_if.m_valid, 1'b0);
        chk("rst_m_data", bus_if.m_data, 32'h0);
        chk("rst_m_last", bus_if.m_last, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_burst(input int len);
        chk("cmd_ready_idle", bus_if.cmd_ready, 1'b1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_len   = 8'(len);
        burst_len  = len;
        beat_idx   = 0;
        beats_seen = 0;
        last_cnt   = 0;
        pops       = 0;
        done       = 1'b0;
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("busy_run", bus_if.busy, 1'b1);
        chk("cmd_ready_run", bus_if.cmd_ready, 1'b0);
    endtask

    task automatic run_burst(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_beats"}, beats_seen, burst_len + 1);
        chk({tag, "_last_cnt"}, last_cnt, 1);
        chk({tag, "_idle_ready"}, bus_if.cmd_ready, 1'b1);
        chk({tag, "_idle_busy"}, bus_if.busy, 1'b0);
    endtask

    initial begin
        int len;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_len   = 8'd0;
        bus_if.m_ready   = 1'b1;
        repeat (2) @(negedge clk);

        // Single-beat burst.
        reset_all();
        put_word(16'h1111);
        put_word(16'h2222);
        idle(2);
        start_burst(0);
        run_burst("single", 50);
        idle(3);
        chk("single_pops", pops, 2);

        // Exact word count leaves surplus in the FIFO.
        reset_all();
        for (int i = 1; i <= 10; i++) put_word(16'(i));
        idle(2);
        start_burst(1);
        run_burst("exact", 50);
        idle(3);
        chk("exact_pops", pops, 4);
        chk("exact_fifo_left", fifo_q.size(), 6);

        // Backpressure: the queue fills to its credit limit and the beat holds.
        reset_all();
        for (int i = 0; i < 16; i++) put_word(16'h0100 + 16'(i));
        idle(2);
        ready_mode = 1;
        start_burst(3);
        idle(12);
        chk("bp_pops_held", pops, 4);
        chk("bp_valid_held", bus_if.m_valid, 1'b1);
        ready_mode = 0;
        run_burst("bp", 100);
        idle(2);
        chk("bp_pops", pops, 8);
        chk("bp_fifo_left", fifo_q.size(), 8);

        // Empty gaps: one word every third cycle.
        reset_all();
        for (int i = 0; i < 6; i++) feed_q.push_back(16'hA000 + 16'(i));
        feed_gap = 2;
        start_burst(2);
        run_burst("gaps", 200);
        chk("gaps_pops", pops, 6);

        // Reset mid-burst with three words queued and one in flight.
        reset_all();
        for (int i = 0; i < 8; i++) put_word(16'h5500 + 16'(i));
        idle(2);
        ready_mode = 1;
        start_burst(3);
        for (int n = 0; n < 20 && pops < 4; n++) cycle();
        chk("mid_pops", pops, 4);
        chk("mid_valid", bus_if.m_valid, 1'b1);
        reset_all();
        put_word(16'hAAAA);
        put_word(16'hBBBB);
        idle(2);
        start_burst(0);
        run_burst("after_rst", 50);
        chk("after_rst_pops", pops, 2);

        // Random-length bursts with random gaps, data and backpressure, plus surplus words.
        for (int b = 0; b < 4; b++) begin
            reset_all();
            len = int'($urandom_range(0, 15));
            for (int i = 0; i < 2 * (len + 1) + 3; i++) feed_q.push_back(16'($urandom));
            feed_gap   = int'($urandom_range(0, 3));
            ready_mode = 2;
            start_burst(len);
            run_burst("rand", 1000);
            idle(20);
            chk("rand_pops", pops, 2 * (len + 1));
        end

        // Maximum length: 256 beats from 512 words.
        reset_all();
        for (int i = 0; i < 512; i++) feed_q.push_back(16'($urandom));
        feed_gap   = 0;
        ready_mode = 2;
        start_burst(255);
        run_burst("max", 6000);
        idle(3);
        chk("max_pops", pops, 512);
        chk("max_fifo_left", fifo_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
